// File: rtl/sccb_init_sequencer_if.sv
// Wishbone bundle between the SCCB init sequencer (master) and the I2C master core (slave).
interface sccb_init_sequencer_if;
    logic [2:0] wbm_adr_o;
    logic [7:0] wbm_dat_o;
    logic [7:0] wbm_dat_i;
    logic       wbm_we_o;
    logic       wbm_stb_o;
    logic       wbm_cyc_o;
    logic       wbm_ack_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/sccb_init_sequencer.sv
// Power-up camera configuration: programs the I2C core, then replays a reg/value table as SCCB writes.
// Optional macro SCCB_DELAY_EN: table entries with reg 8'hF0 become val x 2^16 cycle delays.
module sccb_init_sequencer #(
    parameter logic [7:0]  DEV_ADDR = 8'h42,
    parameter logic [15:0] PRESCALE = 16'd99,
    parameter int          TBL_AW   = 8,
    parameter int          RETRIES  = 3,
    parameter logic [19:0] POLL_MAX = 20'hFFFFF
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  start_i,
    output logic [TBL_AW-1:0]     tbl_addr_o,
    input  logic [15:0]           tbl_data_i,
    sccb_init_sequencer_if.master wb,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [TBL_AW-1:0]     err_idx_o
);
    localparam int            RW        = $clog2(RETRIES + 2);
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRIES);

    localparam logic [2:0] A_PRE_LO = 3'd0;
    localparam logic [2:0] A_PRE_HI = 3'd1;
    localparam logic [2:0] A_CTRL   = 3'd2;
    localparam logic [2:0] A_TXR    = 3'd3;
    localparam logic [2:0] A_CMDST  = 3'd4;

    localparam logic [7:0] C_STA_WR = 8'h90;
    localparam logic [7:0] C_WR     = 8'h10;
    localparam logic [7:0] C_STO_WR = 8'h50;
    localparam logic [7:0] C_STO    = 8'h40;
    localparam logic [7:0] C_EN     = 8'h80;

    typedef enum logic [3:0] {
        S_IDLE, S_PRE_LO, S_PRE_HI, S_EN, S_FETCH, S_TXR, S_CMD,
        S_POLL, S_NSTOP, S_NPOLL, S_ERR, S_FIN
`ifdef SCCB_DELAY_EN
        , S_DLY
`endif
    } state_t;

    state_t            state_q, state_d;
    logic              gap_q, gap_d;
    logic [TBL_AW-1:0] idx_q, idx_d;
    logic              wrap_q, wrap_d;
    logic [15:0]       entry_q, entry_d;
    logic [1:0]        phase_q, phase_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [19:0]       poll_q, poll_d;
    logic              fwait_q, fwait_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [TBL_AW-1:0] eidx_q, eidx_d;
`ifdef SCCB_DELAY_EN
    logic [23:0]       dly_q, dly_d;
`endif

    logic              acc, req, ack, adv;
    logic [2:0]        bus_adr;
    logic [7:0]        bus_dat;
    logic              bus_we;
    logic [19:0]       poll_n;
    logic [TBL_AW:0]   idx_inc;
    logic [7:0]        cur_byte, cur_cmd;
    logic              st_tip, st_nack, st_bbusy;
    logic              unused_st;

    // Access states hold the bus; gap_q forces one idle cycle after every ack.
    assign acc = (state_q == S_PRE_LO) || (state_q == S_PRE_HI) || (state_q == S_EN)
              || (state_q == S_TXR)    || (state_q == S_CMD)    || (state_q == S_POLL)
              || (state_q == S_NSTOP)  || (state_q == S_NPOLL);
    assign req = acc && !gap_q;
    assign ack = req && wb.wbm_ack_i;

    assign wb.wbm_cyc_o = req;
    assign wb.wbm_stb_o = req;
    assign wb.wbm_we_o  = req && bus_we;
    assign wb.wbm_adr_o = req ? bus_adr : 3'd0;
    assign wb.wbm_dat_o = req ? bus_dat : 8'd0;

    assign st_tip    = wb.wbm_dat_i[1];
    assign st_nack   = wb.wbm_dat_i[7];
    assign st_bbusy  = wb.wbm_dat_i[6];
    assign unused_st = ^{wb.wbm_dat_i[5:2], wb.wbm_dat_i[0]};

    assign tbl_addr_o = idx_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_idx_o  = eidx_q;

    always_comb begin
        cur_byte = entry_q[7:0];
        cur_cmd  = C_STO_WR;
        case (phase_q)
            2'd0:    begin cur_byte = DEV_ADDR;       cur_cmd = C_STA_WR; end
            2'd1:    begin cur_byte = entry_q[15:8];  cur_cmd = C_WR;     end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        gap_d   = 1'b0;
        idx_d   = idx_q;
        wrap_d  = wrap_q;
        entry_d = entry_q;
        phase_d = phase_q;
        retry_d = retry_q;
        poll_d  = poll_q;
        fwait_d = fwait_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        eidx_d  = eidx_q;
`ifdef SCCB_DELAY_EN
        dly_d   = dly_q;
`endif
        bus_adr = 3'd0;
        bus_dat = 8'd0;
        bus_we  = 1'b0;
        adv     = 1'b0;
        poll_n  = poll_q + 20'd1;
        idx_inc = {1'b0, idx_q} + {{TBL_AW{1'b0}}, 1'b1};

        if (ack) gap_d = 1'b1;

        case (state_q)
            S_IDLE: if (start_i) begin
                state_d = S_PRE_LO;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                err_d   = 1'b0;
                eidx_d  = '0;
                idx_d   = '0;
                wrap_d  = 1'b0;
                retry_d = '0;
                fwait_d = 1'b0;
            end
            S_PRE_LO: begin
                bus_adr = A_PRE_LO; bus_dat = PRESCALE[7:0]; bus_we = 1'b1;
                if (ack) state_d = S_PRE_HI;
            end
            S_PRE_HI: begin
                bus_adr = A_PRE_HI; bus_dat = PRESCALE[15:8]; bus_we = 1'b1;
                if (ack) state_d = S_EN;
            end
            S_EN: begin
                bus_adr = A_CTRL; bus_dat = C_EN; bus_we = 1'b1;
                if (ack) begin
                    state_d = S_FETCH;
                    fwait_d = 1'b0;
                end
            end
            // First cycle lets the sync ROM see the new index; second cycle latches its data.
            S_FETCH: begin
                if (wrap_q) state_d = S_FIN;
                else if (!fwait_q) fwait_d = 1'b1;
                else begin
                    fwait_d = 1'b0;
                    entry_d = tbl_data_i;
                    phase_d = 2'd0;
                    if (tbl_data_i == 16'hFFFF) state_d = S_FIN;
`ifdef SCCB_DELAY_EN
                    else if (tbl_data_i[15:8] == 8'hF0) begin
                        if (tbl_data_i[7:0] == 8'd0) adv = 1'b1;
                        else begin
                            dly_d   = {tbl_data_i[7:0], 16'h0000};
                            state_d = S_DLY;
                        end
                    end
`endif
                    else state_d = S_TXR;
                end
            end
            S_TXR: begin
                bus_adr = A_TXR; bus_dat = cur_byte; bus_we = 1'b1;
                if (ack) state_d = S_CMD;
            end
            S_CMD: begin
                bus_adr = A_CMDST; bus_dat = cur_cmd; bus_we = 1'b1;
                if (ack) begin
                    state_d = S_POLL;
                    poll_d  = '0;
                end
            end
            S_POLL: begin
                bus_adr = A_CMDST;
                if (ack) begin
                    poll_d = poll_n;
                    if (st_tip) begin
                        if (poll_n >= POLL_MAX) state_d = S_ERR;
                    end else if (st_nack) begin
                        state_d = S_NSTOP;
                    end else if (phase_q != 2'd2) begin
                        phase_d = phase_q + 2'd1;
                        state_d = S_TXR;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            S_NSTOP: begin
                bus_adr = A_CMDST; bus_dat = C_STO; bus_we = 1'b1;
                if (ack) begin
                    state_d = S_NPOLL;
                    poll_d  = '0;
                end
            end
            S_NPOLL: begin
                bus_adr = A_CMDST;
                if (ack) begin
                    poll_d = poll_n;
                    if (st_tip || st_bbusy) begin
                        if (poll_n >= POLL_MAX) state_d = S_ERR;
                    end else if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + 1'b1;
                        phase_d = 2'd0;
                        state_d = S_TXR;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_ERR: begin
                err_d   = 1'b1;
                eidx_d  = idx_q;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
`ifdef SCCB_DELAY_EN
            S_DLY: begin
                if (dly_q <= 24'd1) adv = 1'b1;
                else dly_d = dly_q - 24'd1;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Move to the next table entry; the carry marks a walk past the last index.
        if (adv) begin
            idx_d   = idx_inc[TBL_AW-1:0];
            wrap_d  = wrap_q | idx_inc[TBL_AW];
            retry_d = '0;
            fwait_d = 1'b0;
            state_d = S_FETCH;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            gap_q   <= 1'b0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            entry_q <= '0;
            phase_q <= '0;
            retry_q <= '0;
            poll_q  <= '0;
            fwait_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            eidx_q  <= '0;
`ifdef SCCB_DELAY_EN
            dly_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            entry_q <= entry_d;
            phase_q <= phase_d;
            retry_q <= retry_d;
            poll_q  <= poll_d;
            fwait_q <= fwait_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            eidx_q  <= eidx_d;
`ifdef SCCB_DELAY_EN
            dly_q   <= dly_d;
`endif
        end
    end
endmodule

// File: doc/sccb_init_sequencer.md
Name: sccb_init_sequencer

Overview:
- Wishbone master that configures the camera sensor at power-up through the on-chip I2C master core (8-bit register map, addresses 0-4).
- Programs the prescaler, enables the core, then walks a register/value table: for each entry, one 3-byte SCCB write (device address, register, value).
- Reports done or error to the system.
- Sits between the reset/boot logic and the I2C master's Wishbone slave port. Sole bus master on that port.

Parameters:
- DEV_ADDR, 8'h42: 8-bit device write address (R/W bit = 0).
- PRESCALE, 16'd99: value written to prescaler (lo byte at addr 0, hi byte at addr 1).
- TBL_AW, 8: table address width; maximum table length is 2^TBL_AW entries.
- RETRIES, 3: number of re-attempts of an entry after NACK before error.
- POLL_MAX, 20'hFFFFF: maximum status reads per byte before timeout error.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- start_i  in  1  one-cycle pulse; starts the sequence when idle
- tbl_addr_o  out  TBL_AW  table index
- tbl_data_i  in  16  {reg[15:8], val[7:0]}; valid one cycle after tbl_addr_o changes (sync ROM)
- wbm_adr_o  out  3  Wishbone address
- wbm_dat_o  out  8  write data
- wbm_dat_i  in  8  read data
- wbm_we_o  out  1  write enable
- wbm_stb_o  out  1  strobe
- wbm_cyc_o  out  1  cycle
- wbm_ack_i  in  1  ack (may be combinational from cyc&stb)
- busy_o  out  1  sequence in progress
- done_o  out  1  sticky; sequence completed OK
- err_o  out  1  sticky; sequence aborted
- err_idx_o  out  TBL_AW  table index of failing entry

Behaviour:
Reset:
- All outputs 0; state IDLE; table index 0; retry and poll counters 0.
- Reset mid-sequence aborts immediately; no STOP is issued. Reset of the I2C core is the system's job.

Bus handshake:
- cyc/stb/we/adr/dat asserted together and held until the cycle where ack=1. Read data is captured in that cycle.
- cyc/stb are then low for at least 1 cycle before the next access. This also guarantees the status TIP bit reflects a command written by the previous access.

Command encodings (written to addr 4):
- STA|WR = 8'h90, WR = 8'h10, STO|WR = 8'h50, STO = 8'h40.
- Status (read at addr 4): bit7 = RxACK (1 = NACK), bit1 = TIP.

States:
- IDLE: start_i -> PRE_LO; clears done_o/err_o; busy_o=1. start_i ignored while busy_o=1.
- PRE_LO: write addr 0 = PRESCALE[7:0].
- PRE_HI: write addr 1 = PRESCALE[15:8].
- EN: write addr 2 = 8'h80. Core enable; interrupt disabled.
- FETCH: drive index; wait 1 cycle; latch tbl_data_i.
  - 16'hFFFF -> FIN.
  - Otherwise byte phase 0.
  - If index has wrapped past 2^TBL_AW-1 without a terminator -> FIN.
- TXR: write addr 3 = current byte. Phase 0 = DEV_ADDR, phase 1 = reg, phase 2 = val.
- CMD: write addr 4 = 8'h90 / 8'h10 / 8'h50 for phase 0/1/2.
- POLL: read addr 4, repeated while TIP=1. Poll counter increments each read; reaching POLL_MAX -> ERR.
  - TIP=0, RxACK=0: phase<2 -> phase+1, TXR; phase 2 -> index+1, retry count=0, FETCH.
  - TIP=0, RxACK=1 (NACK) -> NSTOP.
- NSTOP: write addr 4 = 8'h40, then poll until TIP=0 and bus idle (status bit6=0; same POLL_MAX limit).
  - If retry < RETRIES: retry+1, restart the same entry at phase 0.
  - Else -> ERR.
- ERR: err_o=1, err_idx_o=index, busy_o=0 -> IDLE.
- FIN: done_o=1, busy_o=0 -> IDLE.

Other rules:
- done_o/err_o hold until the next accepted start_i or reset.
- Wishbone outputs are driven 0 whenever no access is in flight.

Optional Feature:
- Macro SCCB_DELAY_EN.
- Defined: a table entry with reg == 8'hF0 is a delay command. No bus traffic; wait val × 2^16 wb_clk_i cycles (val=0 -> no wait), then index+1, FETCH. Implemented as a 24-bit down-counter.
- Not defined: 8'hF0 is an ordinary register address, written like any other entry; no counter is synthesized.

Test Plan:
- Reset then start_i with table {16'h1280, 16'hFFFF}, slave model ACKing all bytes -> bus writes in order: (0,8'h63), (1,8'h00), (2,8'h80), (3,8'h42), (4,8'h90), polls…, (3,8'h12), (4,8'h10), …, (3,8'h80), (4,8'h50); then done_o=1, busy_o=0, err_o=0.
- Slave NACKs the device address for entry 2 on every attempt, RETRIES=3 -> 4 attempts, each followed by a write (4,8'h40); then err_o=1, err_idx_o=2, done_o=0.
- Slave NACKs once then ACKs -> a single STOP and retry; sequence completes with done_o=1.
- TIP held at 1 by the model, POLL_MAX=16 -> exactly 16 reads of addr 4, then err_o=1.
- wb_rst_i asserted during POLL -> next cycle all outputs 0 and cyc=0; start_i pulse while busy_o=1 has no effect.
- SCCB_DELAY_EN defined, entry 16'hF002 -> no bus access for 131072 cycles (±2), then the next entry is fetched. Without the macro, the same entry produces writes of 8'hF0 and 8'h02.
